// File: rtl/z_run_monitor.sv
// rtl/z_run_monitor.sv - run-length statistics and sticky alarm on the detector output z
// z is registered once; run FSM measures high runs, alarm FSM latches when the event count hits threshold.
module z_run_monitor #(
  parameter int CNT_W        = 8,
  parameter int RUN_W        = 8,
  parameter int ALARM_THRESH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             z,
  input  logic             clr,
  input  logic             ack,
  output logic [CNT_W-1:0] event_count,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] last_run,
  output logic [RUN_W-1:0] max_run,
  output logic             in_run,
  output logic             alarm
);

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_BLOCK} run_state_e;
  typedef enum logic [1:0] {A_ARMED, A_ALARMED, A_ACKED} alarm_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

  run_state_e       run_state_q, run_state_d;
  alarm_state_e     alarm_state_q, alarm_state_d;
  logic             z_q;
  logic [CNT_W-1:0] event_count_q, event_count_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] last_run_q, last_run_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic             run_start;
  logic             ack_take;

  assign run_start = (run_state_q == R_IDLE) && z_q;
  assign ack_take  = (alarm_state_q == A_ALARMED) && ack;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      z_q           <= 1'b0;
      run_state_q   <= R_IDLE;
      alarm_state_q <= A_ARMED;
      event_count_q <= '0;
      run_len_q     <= '0;
      last_run_q    <= '0;
      max_run_q     <= '0;
    end else begin
      z_q           <= z;
      run_state_q   <= run_state_d;
      alarm_state_q <= alarm_state_d;
      event_count_q <= event_count_d;
      run_len_q     <= run_len_d;
      last_run_q    <= last_run_d;
      max_run_q     <= max_run_d;
    end
  end

  // A run cut short by clr parks in BLOCK so its tail is never counted as a new event.
  always_comb begin
    run_state_d   = run_state_q;
    alarm_state_d = alarm_state_q;
    if (clr) begin
      run_state_d   = z_q ? R_BLOCK : R_IDLE;
      alarm_state_d = A_ARMED;
    end else begin
      case (run_state_q)
        R_IDLE:  if (z_q) run_state_d = R_RUN;
        R_RUN:   if (!z_q) run_state_d = R_IDLE;
        R_BLOCK: if (!z_q) run_state_d = R_IDLE;
        default: run_state_d = R_IDLE;
      endcase
      case (alarm_state_q)
        A_ARMED:   if (event_count_q >= THRESH) alarm_state_d = A_ALARMED;
        A_ALARMED: if (ack) alarm_state_d = A_ACKED;
        A_ACKED:   if (!ack) alarm_state_d = A_ARMED;
        default:   alarm_state_d = A_ARMED;
      endcase
    end
  end

  always_comb begin
    event_count_d = event_count_q;
    run_len_d     = run_len_q;
    last_run_d    = last_run_q;
    if (clr) begin
      event_count_d = '0;
      run_len_d     = '0;
      last_run_d    = '0;
    end else begin
      case (run_state_q)
        R_IDLE: if (z_q) run_len_d = RUN_W'(1);
        R_RUN: begin
          if (z_q) begin
            if (run_len_q != RUN_MAX) run_len_d = run_len_q + 1'b1;
          end else begin
            last_run_d = run_len_q;
            run_len_d  = '0;
          end
        end
        default: run_len_d = '0;
      endcase
      // An ack restarts counting; a run starting on the ack clock is kept as the first new event.
      if (ack_take) begin
        event_count_d = CNT_W'(run_start);
      end else if (run_start && (event_count_q != CNT_MAX)) begin
        event_count_d = event_count_q + 1'b1;
      end
    end
    if (clr) begin
      max_run_d = '0;
    end else begin
      max_run_d = (run_len_d > max_run_q) ? run_len_d : max_run_q;
    end
  end

  always_comb begin
    in_run      = (run_state_q == R_RUN);
    alarm       = (alarm_state_q == A_ALARMED);
    event_count = event_count_q;
    run_len     = run_len_q;
    last_run    = last_run_q;
    max_run     = max_run_q;
  end

endmodule

// File: tb/tb_z_run_monitor.sv
// tb/tb_z_run_monitor.sv - scoreboard bench for z_run_monitor, default and narrow-width instances
// A run-level reference model predicts each cycle; a negedge monitor pops and compares.
module tb_z_run_monitor;

  localparam int THRESH = 4;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       z = 1'b0, clr = 1'b0, ack = 1'b0;
  logic [7:0] a_event_count, a_run_len, a_last_run, a_max_run;
  logic       a_in_run, a_alarm;
  logic [2:0] b_event_count, b_run_len, b_last_run, b_max_run;
  logic       b_in_run, b_alarm;

  z_run_monitor #(.CNT_W(8), .RUN_W(8), .ALARM_THRESH(THRESH)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .z(z), .clr(clr), .ack(ack),
    .event_count(a_event_count), .run_len(a_run_len), .last_run(a_last_run),
    .max_run(a_max_run), .in_run(a_in_run), .alarm(a_alarm)
  );

  z_run_monitor #(.CNT_W(3), .RUN_W(3), .ALARM_THRESH(THRESH)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .z(z), .clr(clr), .ack(ack),
    .event_count(b_event_count), .run_len(b_run_len), .last_run(b_last_run),
    .max_run(b_max_run), .in_run(b_in_run), .alarm(b_alarm)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit zq;
    bit in_run;
    bit blocked;
    bit alarm;
    bit acked;
    int events;
    int cur;
    int last;
    int maxr;
  } mdl_t;

  typedef struct {
    int   tag;
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t q[$];
  mdl_t ma, mb;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic mdl_t model_reset();
    mdl_t r;
    r.zq = 0; r.in_run = 0; r.blocked = 0; r.alarm = 0; r.acked = 0;
    r.events = 0; r.cur = 0; r.last = 0; r.maxr = 0;
    return r;
  endfunction

  // One clock of the observer: z is what gets sampled, everything else acts on the previous sample.
  function automatic mdl_t model_step(mdl_t m, bit zi, bit ci, bit ai, int cmax, int rmax);
    mdl_t n;
    bit   start;
    n = m;
    n.zq = zi;
    if (ci) begin
      n = model_reset();
      n.zq = zi;
      n.blocked = m.zq;
      return n;
    end
    start = m.zq && !m.in_run && !m.blocked;
    if (m.blocked) n.blocked = m.zq;
    if (start) begin
      n.in_run = 1; n.cur = 1;
    end else if (m.in_run && m.zq) begin
      n.cur = (m.cur + 1 > rmax) ? rmax : m.cur + 1;
    end else if (m.in_run) begin
      n.in_run = 0; n.last = m.cur; n.cur = 0;
    end
    if (m.alarm && ai) n.events = start ? 1 : 0;
    else if (start) n.events = (m.events + 1 > cmax) ? cmax : m.events + 1;
    if (m.alarm) begin
      if (ai) begin n.alarm = 0; n.acked = 1; end
    end else if (m.acked) begin
      if (!ai) n.acked = 0;
    end else if (m.events >= THRESH) begin
      n.alarm = 1;
    end
    n.maxr = (n.cur > m.maxr) ? n.cur : m.maxr;
    return n;
  endfunction

  task automatic chk(input string pfx, input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s cycle %0d: got %0d expected %0d", pfx, name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit zi, input bit ci, input bit ai, input bit ri);
    exp_t e;
    @(negedge Clock);
    #1;
    if (ri) begin
      Resetn = 1'b0;
      #2;
      Resetn = 1'b1;
      ma = model_reset();
      mb = model_reset();
    end
    z = zi; clr = ci; ack = ai;
    ma = model_step(ma, zi, ci, ai, 255, 255);
    mb = model_step(mb, zi, ci, ai, 7, 7);
    e.tag = cyc + 1;
    e.a = ma;
    e.b = mb;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        chk("a", "event_count", 32'(a_event_count), e.a.events);
        chk("a", "run_len",     32'(a_run_len),     e.a.cur);
        chk("a", "last_run",    32'(a_last_run),    e.a.last);
        chk("a", "max_run",     32'(a_max_run),     e.a.maxr);
        chk("a", "in_run",      32'(a_in_run),      int'(e.a.in_run));
        chk("a", "alarm",       32'(a_alarm),       int'(e.a.alarm));
        chk("b", "event_count", 32'(b_event_count), e.b.events);
        chk("b", "run_len",     32'(b_run_len),     e.b.cur);
        chk("b", "last_run",    32'(b_last_run),    e.b.last);
        chk("b", "max_run",     32'(b_max_run),     e.b.maxr);
        chk("b", "in_run",      32'(b_in_run),      int'(e.b.in_run));
        chk("b", "alarm",       32'(b_alarm),       int'(e.b.alarm));
      end
    end
  end

  initial begin : stimulus
    exp_t e0;
    int   left;
    bit   lvl;
    bit   ack_lvl;
    ma = model_reset();
    mb = model_reset();
    e0.tag = 0; e0.a = ma; e0.b = mb;
    q.push_back(e0);
    @(negedge Clock);
    #1;
    Resetn = 1'b1;
    repeat (2) step(0, 0, 0, 0);
    // single 5-cycle run
    repeat (5) step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // pulses up to the threshold, alarm held without ack
    repeat (4) begin step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); end
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    // re-arm, then ack on the same clock a run starts
    repeat (4) begin step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); end
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    // clr mid-run
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // saturation of the narrow instance
    repeat (9) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    repeat (10) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // asynchronous reset pulse mid-run with z held high
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // randomized runs, gaps, acks, clears and resets
    left = 0; lvl = 0; ack_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        lvl = ~lvl;
        left = lvl ? $urandom_range(1, 12) : $urandom_range(1, 4);
      end
      left--;
      if ($urandom_range(0, 7) == 0) ack_lvl = ~ack_lvl;
      step(lvl, ($urandom_range(0, 59) == 0), ack_lvl, ($urandom_range(0, 299) == 0));
    end
    repeat (3) @(negedge Clock);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
